// File: rtl/qos_pkg.sv
// qos_pkg: shared channel count, FSM encodings, counter width and grant decode helpers
package qos_pkg;
   localparam int NUM_CH    = 4;
   localparam int QOS_IDX_W = $clog2(NUM_CH);
   localparam int QOS_CNT_W = 32;
   typedef enum logic [1:0] {
      QOS_REQ_IDLE     = 2'd0,
      QOS_REQ_ISSUE    = 2'd1,
      QOS_REQ_WAIT_RSP = 2'd2,
      QOS_REQ_DONE     = 2'd3
   } qos_req_state_e;
   function automatic logic [QOS_IDX_W-1:0] onehot_to_idx(input logic [NUM_CH-1:0] oh);
      logic [QOS_IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_CH; i++)
         if (oh[i]) idx = QOS_IDX_W'(i);
      return idx;
   endfunction
   function automatic logic is_onehot(input logic [NUM_CH-1:0] oh);
      return (oh != '0) && ((oh & (oh - 1'b1)) == '0);
   endfunction
endpackage

// File: rtl/qos_req_mux.sv
// qos_req_mux: selects one channel's we/addr/wdata out of the flattened request ports
module qos_req_mux
   import qos_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic [QOS_IDX_W-1:0]     i_sel,
   input  logic [NUM_CH-1:0]        i_we,
   input  logic [NUM_CH*ADDR_W-1:0] i_addr,
   input  logic [NUM_CH*DATA_W-1:0] i_wdata,
   output logic                     o_we,
   output logic [ADDR_W-1:0]        o_addr,
   output logic [DATA_W-1:0]        o_wdata
);
   assign o_we    = i_we[i_sel];
   assign o_addr  = i_addr[i_sel*ADDR_W +: ADDR_W];
   assign o_wdata = i_wdata[i_sel*DATA_W +: DATA_W];
endmodule

// File: rtl/qos_requester.sv
// qos_requester: serves the QoS manager's granted channel with one memory command; optional QOS_REQ_TIMEOUT_EN adds a response timeout and timeout_err
module qos_requester
   import qos_pkg::*;
#(
   parameter int NUM_CH         = 4,
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                     sys_clk,
   input  logic                     sys_rst,
   input  logic [NUM_CH-1:0]        grant,
   output logic                     request_completed,
   input  logic [NUM_CH-1:0]        req_valid,
   output logic [NUM_CH-1:0]        req_ready,
   input  logic [NUM_CH-1:0]        req_we,
   input  logic [NUM_CH*ADDR_W-1:0] req_addr,
   input  logic [NUM_CH*DATA_W-1:0] req_wdata,
   output logic                     mem_cmd_valid,
   input  logic                     mem_cmd_ready,
   output logic                     mem_cmd_we,
   output logic [ADDR_W-1:0]        mem_cmd_addr,
   output logic [DATA_W-1:0]        mem_cmd_wdata,
   input  logic                     mem_rsp_valid,
   input  logic [DATA_W-1:0]        mem_rsp_rdata,
   output logic [NUM_CH-1:0]        rsp_valid,
   output logic [DATA_W-1:0]        rsp_rdata,
   input  logic [1:0]               cnt_sel,
   output logic [QOS_CNT_W-1:0]     cnt_value
`ifdef QOS_REQ_TIMEOUT_EN
   ,
   output logic                     timeout_err
`endif
);
   localparam logic [NUM_CH-1:0] ONE = NUM_CH'(1);
   qos_req_state_e                    r_state, w_next;
   logic [QOS_IDX_W-1:0]              r_ch, w_gidx;
   logic                              r_we, w_we;
   logic [ADDR_W-1:0]                 r_addr, w_addr;
   logic [DATA_W-1:0]                 r_wdata, w_wdata, r_rsp_rdata;
   logic [NUM_CH-1:0]                 r_rsp_valid;
   logic                              r_completed;
   logic [NUM_CH-1:0][QOS_CNT_W-1:0]  r_cnt;
   logic                              w_gok, w_accept, w_skip, w_rsp, w_tmo;
   assign w_gidx   = onehot_to_idx(grant);
   // r_completed doubles as the settle cycle: the manager still shows the old grant then
   assign w_gok    = (r_state == QOS_REQ_IDLE) && !r_completed && is_onehot(grant);
   assign w_accept = w_gok && req_valid[w_gidx];
   assign w_skip   = w_gok && !req_valid[w_gidx];
   assign w_rsp    = (r_state == QOS_REQ_WAIT_RSP) && mem_rsp_valid;
   qos_req_mux #(
      .NUM_CH (NUM_CH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_mux (
      .i_sel   (w_gidx),
      .i_we    (req_we),
      .i_addr  (req_addr),
      .i_wdata (req_wdata),
      .o_we    (w_we),
      .o_addr  (w_addr),
      .o_wdata (w_wdata)
   );
   // next-state and handshake outputs
   always_comb begin
      w_next        = r_state;
      req_ready     = w_accept ? (ONE << w_gidx) : '0;
      mem_cmd_valid = (r_state == QOS_REQ_ISSUE);
      unique case (r_state)
         QOS_REQ_IDLE:     w_next = w_accept ? QOS_REQ_ISSUE : QOS_REQ_IDLE;
         QOS_REQ_ISSUE:    w_next = mem_cmd_ready ? QOS_REQ_WAIT_RSP : QOS_REQ_ISSUE;
         QOS_REQ_WAIT_RSP: w_next = (w_rsp || w_tmo) ? QOS_REQ_DONE : QOS_REQ_WAIT_RSP;
         QOS_REQ_DONE:     w_next = QOS_REQ_IDLE;
         default:          w_next = QOS_REQ_IDLE;
      endcase
   end
   // state register and completion pulse toward the manager
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_state     <= QOS_REQ_IDLE;
         r_completed <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_completed <= w_skip || (r_state == QOS_REQ_DONE);
      end
   end
   // latch the accepted channel's command so later grant/input changes cannot disturb it
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_ch    <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else if (w_accept) begin
         r_ch    <= w_gidx;
         r_we    <= w_we;
         r_addr  <= w_addr;
         r_wdata <= w_wdata;
      end
   end
   // route the response (or a timeout abort with zero data) back to the owning channel
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_rsp_valid <= '0;
         r_rsp_rdata <= '0;
      end else begin
         r_rsp_valid <= (w_rsp || w_tmo) ? (ONE << r_ch) : '0;
         if (w_rsp)
            r_rsp_rdata <= mem_rsp_rdata;
         else if (w_tmo)
            r_rsp_rdata <= '0;
      end
   end
   // per-channel completion counters, wrapping naturally at 2^32
   always_ff @(posedge sys_clk) begin
      if (sys_rst)
         r_cnt <= '0;
      else if (w_rsp)
         r_cnt[r_ch] <= r_cnt[r_ch] + 1'b1;
   end
`ifdef QOS_REQ_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] r_tmo;
   logic             r_timeout_err;
   assign w_tmo = (r_state == QOS_REQ_WAIT_RSP) && !mem_rsp_valid &&
                  (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
   // count cycles spent waiting for a response; error flag is sticky until reset
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_tmo         <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_tmo <= (r_state == QOS_REQ_WAIT_RSP) ? r_tmo + 1'b1 : '0;
         if (w_tmo)
            r_timeout_err <= 1'b1;
      end
   end
   assign timeout_err = r_timeout_err;
`else
   assign w_tmo = 1'b0;
`endif
   assign request_completed = r_completed;
   assign mem_cmd_we        = r_we;
   assign mem_cmd_addr      = r_addr;
   assign mem_cmd_wdata     = r_wdata;
   assign rsp_valid         = r_rsp_valid;
   assign rsp_rdata         = r_rsp_rdata;
   assign cnt_value         = r_cnt[cnt_sel];
endmodule

// File: doc/qos_requester.md
Name: qos_requester

Overview:
- Requester-side counterpart of the round-robin QoS grant manager.
- Consumes the manager's one-hot grant and holds four per-channel request ports.
- Issues the granted channel's single command to the memory port, routes the response back to that channel, and pulses request_completed so the manager rotates priority.
- Keeps a per-channel 32-bit completion counter.

Parameters:
- NUM_CH, 4, number of channels; must equal the manager's grant width.
- ADDR_W, 32, request address width.
- DATA_W, 32, write/read data width.
- TIMEOUT_CYCLES, 256, response timeout limit; used only with the optional feature.

Ports:
- sys_clk  in  1  clock
- sys_rst  in  1  synchronous active-high reset
- grant  in  NUM_CH  one-hot grant from the QoS manager
- request_completed  out  1  one-cycle pulse to the manager: service finished or channel skipped
- req_valid  in  NUM_CH  per-channel request pending
- req_ready  out  NUM_CH  one-hot acceptance pulse
- req_we  in  NUM_CH  per-channel write enable
- req_addr  in  NUM_CH*ADDR_W  flattened addresses; channel i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_CH*DATA_W  flattened write data
- mem_cmd_valid  out  1  command valid
- mem_cmd_ready  in  1  command accepted
- mem_cmd_we  out  1  command write enable
- mem_cmd_addr  out  ADDR_W  command address
- mem_cmd_wdata  out  DATA_W  command write data
- mem_rsp_valid  in  1  response valid; exactly one per command, reads and writes alike
- mem_rsp_rdata  in  DATA_W  read data
- rsp_valid  out  NUM_CH  one-hot response pulse to the owning channel
- rsp_rdata  out  DATA_W  response data; valid when any rsp_valid bit is set
- cnt_sel  in  2  counter select
- cnt_value  out  32  completion count of the selected channel; combinational read

Behaviour:
- Reset: sys_rst is sampled on sys_clk only.
  - State goes to IDLE.
  - All outputs go to 0: request_completed, req_ready, mem_cmd_*, rsp_valid, rsp_rdata.
  - All counters go to 0.
  - Reset mid-transaction abandons the in-flight command; a later mem_rsp_valid in IDLE is ignored.
- FSM states: IDLE, ISSUE, WAIT_RSP, DONE.
- IDLE:
  - Grant one-hot with req_valid[g]=1: pulse req_ready[g] for one cycle; latch channel g, we, addr, wdata; go to ISSUE next cycle.
  - Grant one-hot with req_valid[g]=0: pulse request_completed for one cycle (skip) and stay in IDLE. This prevents the manager from stalling on an idle channel.
  - Grant zero or not one-hot: do nothing and stay in IDLE.
- ISSUE:
  - mem_cmd_valid=1 with the latched fields held stable.
  - Leave when mem_cmd_valid && mem_cmd_ready, then go to WAIT_RSP.
  - Back-pressure is unbounded.
- WAIT_RSP:
  - On mem_rsp_valid: register rsp_rdata, pulse rsp_valid[g], increment counter[g] (wraps 0xFFFFFFFF to 0), go to DONE.
  - A response arriving in the same cycle as command acceptance is not allowed; the memory side guarantees at least one cycle of latency.
- DONE:
  - Pulse request_completed for one cycle, then go to IDLE.
- Latency: from the IDLE accept edge, mem_cmd_valid rises 1 cycle later. request_completed fires 1 cycle after rsp_valid.
- Grant changes while in ISSUE, WAIT_RSP or DONE are ignored; the latched channel is served to completion.
- Minimum service time is 4 cycles (accept, issue, response, done). A skip takes 1 cycle.
- The manager advances its grant one cycle after the request_completed pulse. Therefore, after DONE or a skip, IDLE ignores grant for one cycle (settle cycle) so a stale grant is never re-used.

Optional Feature:
- Macro: QOS_REQ_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_RSP.
  - Reaching TIMEOUT_CYCLES without mem_rsp_valid aborts the transaction.
  - Abort asserts sticky output timeout_err (extra 1-bit port, cleared only by reset), pulses rsp_valid[g] with rsp_rdata=0, and does not increment counter[g].
  - The FSM then goes to DONE.
  - A late response after the timeout is dropped.
- Undefined: no counter, no timeout_err port; WAIT_RSP waits indefinitely.

Decomposition:
- Shared package qos_pkg:
  - NUM_CH.
  - FSM state encodings QOS_REQ_IDLE/ISSUE/WAIT_RSP/DONE (2 bits).
  - Counter width constant QOS_CNT_W=32.
  - onehot_to_idx function.
- One natural sub-module: qos_req_mux, a combinational flattened-port select of we/addr/wdata by channel index.
- FSM, counters and timeout stay in qos_requester.

Test Plan:
- Reset then grant=4'b0010, req_valid=4'b0010, req_we=0, addr[1]=0x100, rsp rdata=0xDEADBEEF:
  - req_ready=4'b0010 pulse.
  - mem_cmd_addr=0x100.
  - rsp_valid=4'b0010 with rsp_rdata=0xDEADBEEF.
  - request_completed one cycle later.
  - cnt_sel=1 reads 1.
- grant=4'b0100, req_valid=0: request_completed pulses exactly once; no mem_cmd_valid.
- mem_cmd_ready held low 10 cycles: mem_cmd_valid/addr/wdata stay stable; exactly one accept.
- grant switches 0001->1000 during WAIT_RSP: response still goes to rsp_valid=4'b0001; counter[0] increments, counter[3] does not.
- Preload counter[2]=0xFFFFFFFF via repeated completions (or force), then one more completion: cnt_value=0; sys_rst asserted in WAIT_RSP returns to IDLE with all outputs 0.
- With QOS_REQ_TIMEOUT_EN and TIMEOUT_CYCLES=8: no response -> timeout_err=1 after 8 WAIT_RSP cycles, rsp_rdata=0, request_completed pulses, counter unchanged.
